fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  - Program-counter / instruction-register stage of the SIMPLE processor. Sits directly
//    downstream of the 5-phase sequencer and consumes its one-hot phase_bus.
//  - Phase 0 fetches and latches the instruction. Phase 4 commits the next PC (sequential
//    or branch). A halt/exec run-state machine freezes or resumes the datapath.
// PARAMETERS
//  - ADDR_W  default 12  instruction address width; PC wraps modulo 2**ADDR_W
//  - DATA_W  default 16  instruction word width
//  - RESET_PC  default 0  PC value loaded on reset
// PORTS
//  - clock         in   1       rising-edge clock
//  - reset         in   1       reset, synchronous, active-high
//  - phase_bus     in   5       one-hot phase strobe; bit k = phase k, each bit high for 1 cycle
//  - exec          in   1       level from run switch; rising edge resumes from HALT
//  - imem_rdata    in   DATA_W  instruction memory read data, valid same cycle as imem_re
//  - branch_taken  in   1       from execute/decode, sampled on phase 4 only
//  - branch_target in   ADDR_W  branch destination, sampled with branch_taken
//  - halt_req      in   1       decoded HLT, sampled on phase 4 only
//  - imem_addr     out  ADDR_W  = pc (combinational)
//  - imem_re       out  1       = phase_bus[0] & (state==RUN) (combinational)
//  - pc            out  ADDR_W  current program counter
//  - pc_plus1      out  ADDR_W  registered pc+1, captured at phase 0 (link value for BAL)
//  - ir            out  DATA_W  instruction register
//  - ir_valid      out  1       ir holds a word fetched since the last reset or resume
//  - halted        out  1       high in state HALT
//  - phase_err     out  1       sticky: phase_bus was non-zero and not one-hot
// BEHAVIOUR
//  - Reset: pc=RESET_PC, pc_plus1=RESET_PC+1, ir=0, ir_valid=0, halted=0, phase_err=0,
//    state=RUN. Applies on any edge, including mid-instruction; no pending update survives.
//  - States:
//    - RUN: fetch/commit active.
//    - HALT: pc/ir frozen; phase_bus ignored except for the phase_err check.
//  - RUN, phase_bus==5'b00001: ir<=imem_rdata, pc_plus1<=pc+1 (mod 2**ADDR_W), ir_valid<=1.
//    Fetch latency is 0: data is captured on the same edge the strobe is sampled.
//  - RUN, phase_bus==5'b10000:
//    - halt_req=1: pc<=pc_plus1, state<=HALT. Halt wins over branch_taken.
//    - else branch_taken=1: pc<=branch_target.
//    - else: pc<=pc_plus1.
//  - Phases 1-3: no state change in this block.
//  - phase_bus==0: idle cycle, no change.
//  - Illegal phase_bus (popcount>1): no register update except phase_err<=1. phase_err
//    is cleared only by reset.
//  - HALT:
//    - exec rising edge (registered 0->1, detected by the oneshot sub-module):
//      state<=RUN, ir_valid<=0, effective the next edge.
//    - exec held high does not re-trigger.
//    - exec edge coincident with any phase_bus bit: resume only; that phase is ignored.
//  - exec edges seen while in RUN are ignored.
//  - PC wrap: pc=2**ADDR_W-1 with sequential commit gives pc=0; no flag.
//  - branch_target is used verbatim (no offset arithmetic here).
// STRUCTURE
//  - simple_ps_pkg:
//    - phase index localparams P_FETCH=0 .. P_COMMIT=4
//    - PHASE_W=5
//    - run-state encoding RUN/HALT
//    - default ADDR_W/DATA_W
//  - Sub-module oneshot: 1-bit registered rising-edge detector, synchronous reset clears
//    the history to 0. Shared with the sequencer's reset one-shot.
//  - Remaining logic is flat: PC/IR registers, state register, one-hot check.
// TESTING
//  - Reset, then phases 0..4 with imem_rdata=16'hA5C3, no branch/halt
//    -> ir=A5C3, ir_valid=1, pc 0->1 after phase 4, pc_plus1=1.
//  - pc=12'h010, phase 4 with branch_taken=1, target=12'h3F0 -> pc=3F0. Next phase 0
//    -> imem_addr=3F0, imem_re=1.
//  - Phase 4 with halt_req=1 and branch_taken=1 at pc=5 -> pc=6, halted=1. Full phase
//    cycle -> pc/ir unchanged, imem_re=0. exec 0->1 -> halted=0, ir_valid=0. exec held
//    high 10 cycles -> no further effect.
//  - pc=12'hFFF, sequential commit -> pc=0. phase_bus=5'b00011 -> pc/ir unchanged,
//    phase_err=1; stays 1 after legal phases until reset.
//  - Reset asserted between phase 0 and phase 4 (ir loaded, pc=7) -> next edge pc=0,
//    ir=0, ir_valid=0. Following phase 4 commits pc=1 (pc_plus1 reset value).

Source files
------------

// File: rtl/simple_ps_pkg.sv
// Shared definitions for the SIMPLE processor phase-driven datapath.
package simple_ps_pkg;

    // Sequencer phase indices and phase bus width
    localparam int PHASE_W  = 5;
    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_READ   = 2;
    localparam int P_EXEC   = 3;
    localparam int P_COMMIT = 4;

    // Default datapath widths
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Run-state encoding
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

    // More than one phase strobe set at once
    function automatic logic phase_illegal(input logic [PHASE_W-1:0] p);
        return (p & (p - PHASE_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/oneshot.sv
// Rising-edge detector: pulse is high for the cycle in which d is high
// and its registered history is low.
module oneshot (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Track the previous sample of d; reset forgets any prior level
    always_ff @(posedge clock) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/fetch_stage.sv
// PC / instruction-register stage. Fetches on phase 0, commits the next PC
// on phase 4, and freezes in HALT until the run switch is toggled on.
module fetch_stage
    import simple_ps_pkg::*;
#(
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PHASE_W-1:0]  phase_bus,
    input  logic                exec,
    input  logic [DATA_W-1:0]   imem_rdata,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                halt_req,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_re,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus1,
    output logic [DATA_W-1:0]   ir,
    output logic                ir_valid,
    output logic                halted,
    output logic                phase_err
);

    localparam logic [PHASE_W-1:0] PH_FETCH  = PHASE_W'(1) << P_FETCH;
    localparam logic [PHASE_W-1:0] PH_COMMIT = PHASE_W'(1) << P_COMMIT;

    run_state_t state;
    logic       exec_rise;

    oneshot u_exec_edge (
        .clock (clock),
        .reset (reset),
        .d     (exec),
        .pulse (exec_rise)
    );

    assign imem_addr = pc;
    assign imem_re   = phase_bus[P_FETCH] & (state == RUN);
    assign halted    = (state == HALT);

    // PC/IR/run-state update; illegal strobes only raise the sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= RESET_PC;
            pc_plus1  <= RESET_PC + ADDR_W'(1);
            ir        <= '0;
            ir_valid  <= 1'b0;
            phase_err <= 1'b0;
            state     <= RUN;
        end else begin
            if (phase_illegal(phase_bus)) phase_err <= 1'b1;
            case (state)
                RUN: begin
                    if (phase_bus == PH_FETCH) begin
                        ir       <= imem_rdata;
                        pc_plus1 <= pc + ADDR_W'(1);
                        ir_valid <= 1'b1;
                    end else if (phase_bus == PH_COMMIT) begin
                        // Halt takes priority; the halted PC still points past HLT
                        if (halt_req) begin
                            pc    <= pc_plus1;
                            state <= HALT;
                        end else if (branch_taken) begin
                            pc <= branch_target;
                        end else begin
                            pc <= pc_plus1;
                        end
                    end
                end
                HALT: begin
                    // Any phase strobe on the resume edge is deliberately dropped
                    if (exec_rise) begin
                        state    <= RUN;
                        ir_valid <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes hand-computed expected
// snapshots into a scoreboard queue, a negedge monitor pops and compares.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  phase_bus;
    logic        exec;
    logic [15:0] imem_rdata;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        halt_req;
    logic [11:0] imem_addr;
    logic        imem_re;
    logic [11:0] pc;
    logic [11:0] pc_plus1;
    logic [15:0] ir;
    logic        ir_valid;
    logic        halted;
    logic        phase_err;

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .phase_bus     (phase_bus),
        .exec          (exec),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .imem_addr     (imem_addr),
        .imem_re       (imem_re),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .halted        (halted),
        .phase_err     (phase_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [11:0] pc;
        logic [11:0] pp1;
        logic [15:0] ir;
        logic        v;
        logic        h;
        logic        e;
        logic        re;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", n, f, act, req);
        end
    endtask

    // Monitor: compare every queued snapshot against the DUT mid-cycle
    always @(negedge clock) begin : monitor
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.name, "pc",        32'(pc),        32'(x.pc));
            chk(x.name, "imem_addr", 32'(imem_addr), 32'(x.pc));
            chk(x.name, "pc_plus1",  32'(pc_plus1),  32'(x.pp1));
            chk(x.name, "ir",        32'(ir),        32'(x.ir));
            chk(x.name, "ir_valid",  32'(ir_valid),  32'(x.v));
            chk(x.name, "halted",    32'(halted),    32'(x.h));
            chk(x.name, "phase_err", 32'(phase_err), 32'(x.e));
            chk(x.name, "imem_re",   32'(imem_re),   32'(x.re));
        end
    end

    // Drive one phase strobe for a single clock edge, then return to idle
    task automatic step(input logic [4:0] ph);
        phase_bus = ph;
        @(posedge clock);
        #1;
        phase_bus = '0;
    endtask

    task automatic expect_state(input string n, input logic [11:0] p, input logic [11:0] pp,
                                input logic [15:0] i, input logic v, input logic h,
                                input logic e, input logic re);
        exp_t x;
        x.name = n; x.pc = p; x.pp1 = pp; x.ir = i; x.v = v; x.h = h; x.e = e; x.re = re;
        sb.push_back(x);
        @(negedge clock);
        #1;
    endtask

    // Hold phase 0 across the next negedge so imem_re/imem_addr are checked
    // before the fetch edge, then let the fetch edge happen.
    task automatic probe_fetch(input string n, input logic [11:0] p, input logic [11:0] pp,
                               input logic [15:0] i, input logic v, input logic h,
                               input logic re);
        @(posedge clock);
        #1;
        phase_bus = 5'b00001;
        expect_state(n, p, pp, i, v, h, 1'b0, re);
        @(posedge clock);
        #1;
        phase_bus = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b1; phase_bus = '0; exec = 1'b0; imem_rdata = '0;
        branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
        step(5'b0); step(5'b0);
        reset = 1'b0;
        expect_state("reset", 12'h000, 12'h001, 16'h0000, 0, 0, 0, 0);

        // Plain sequential instruction
        imem_rdata = 16'hA5C3;
        step(5'b00001);
        expect_state("fetch", 12'h000, 12'h001, 16'hA5C3, 1, 0, 0, 0);
        step(5'b00010); step(5'b00100); step(5'b01000); step(5'b10000);
        expect_state("commit_seq", 12'h001, 12'h001, 16'hA5C3, 1, 0, 0, 0);

        // Branch to 010, then 010 -> 3F0
        imem_rdata = 16'h1111; step(5'b00001);
        branch_taken = 1'b1; branch_target = 12'h010; step(5'b10000);
        imem_rdata = 16'h2222; step(5'b00001);
        branch_target = 12'h3F0; step(5'b10000);
        branch_taken = 1'b0;
        expect_state("branch", 12'h3F0, 12'h011, 16'h2222, 1, 0, 0, 0);
        imem_rdata = 16'h3333;
        probe_fetch("fetch_at_target", 12'h3F0, 12'h011, 16'h2222, 1, 0, 1);
        expect_state("fetch_after_branch", 12'h3F0, 12'h3F1, 16'h3333, 1, 0, 0, 0);

        // Halt beats branch at pc=5
        branch_taken = 1'b1; branch_target = 12'h005; step(5'b10000);
        branch_taken = 1'b0;
        imem_rdata = 16'h4444; step(5'b00001);
        halt_req = 1'b1; branch_taken = 1'b1; branch_target = 12'h123; step(5'b10000);
        halt_req = 1'b0; branch_taken = 1'b0;
        expect_state("halt", 12'h006, 12'h006, 16'h4444, 1, 1, 0, 0);
        imem_rdata = 16'h5555;
        probe_fetch("halt_no_re", 12'h006, 12'h006, 16'h4444, 1, 1, 0);
        step(5'b00010); step(5'b00100); step(5'b01000); step(5'b10000); step(5'b00001);
        expect_state("halt_frozen", 12'h006, 12'h006, 16'h4444, 1, 1, 0, 0);

        // Resume, then keep exec high across a second halt
        exec = 1'b1;
        step(5'b0); step(5'b0);
        expect_state("resume", 12'h006, 12'h006, 16'h4444, 0, 0, 0, 0);
        imem_rdata = 16'h6666; step(5'b00001); step(5'b10000);
        imem_rdata = 16'h7777; step(5'b00001);
        halt_req = 1'b1; step(5'b10000); halt_req = 1'b0;
        step(5'b0); step(5'b0); step(5'b0); step(5'b0);
        expect_state("exec_held", 12'h008, 12'h008, 16'h7777, 1, 1, 0, 0);

        // Resume edge coincident with a fetch strobe: the fetch is dropped
        exec = 1'b0; step(5'b0);
        exec = 1'b1; imem_rdata = 16'h8888; step(5'b00001);
        step(5'b0);
        exec = 1'b0;
        expect_state("resume_coincident", 12'h008, 12'h008, 16'h7777, 0, 0, 0, 0);

        // PC wrap at top of address space
        branch_taken = 1'b1; branch_target = 12'hFFF; step(5'b10000);
        branch_taken = 1'b0;
        imem_rdata = 16'h9999; step(5'b00001); step(5'b10000);
        expect_state("wrap", 12'h000, 12'h000, 16'h9999, 1, 0, 0, 0);

        // Illegal strobe and sticky error
        imem_rdata = 16'hAAAA; step(5'b00011);
        expect_state("illegal", 12'h000, 12'h000, 16'h9999, 1, 0, 1, 0);
        step(5'b00001); step(5'b10000);
        expect_state("err_sticky", 12'h001, 12'h001, 16'hAAAA, 1, 0, 1, 0);

        // Reset mid-instruction at pc=7 after a fetch
        branch_taken = 1'b1; branch_target = 12'h007; step(5'b10000);
        branch_taken = 1'b0;
        imem_rdata = 16'hBBBB; step(5'b00001);
        reset = 1'b1; step(5'b0); reset = 1'b0;
        expect_state("mid_reset", 12'h000, 12'h001, 16'h0000, 0, 0, 0, 0);
        step(5'b10000);
        expect_state("reset_pp1_commit", 12'h001, 12'h001, 16'h0000, 0, 0, 0, 0);

        step(5'b0); step(5'b0);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
